// File: rtl/instr_sequencer_pkg.sv
// Shared defines for the microcode sequencer: bus drivers, states,
// opcode constants and the opcode legality helper.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    NOP,
    IR_R1,
    IR_R2,
    IR_RD,
    RF,
    ALU,
    PC_PLUS_4
  } data_bus_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_SEL_R1,
    S_READ_R1,
    S_SEL_R2,
    S_READ_R2,
    S_IMM_R2,
    S_SEL_RD,
    S_WRITE_RD,
    S_PC_INC
  } seq_state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_NAND = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_NOR;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Microcode sequencer: owns the common bus and walks each accepted
// instruction through fetch, operand read, writeback and PC increment.
// Ports: clock/reset_n, instr_valid/instr_ready handshake, halt,
// opcode/imm_instruction from IR, bus select, load enables,
// rf_write_read, retired_count, illegal_seen.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       halt,
  input  logic [3:0] opcode,
  input  logic       imm_instruction,
  output data_bus_t  data_bus_sel,
  output logic       pc_load_en,
  output logic       ir_load_en,
  output logic       alu_src1_load_en,
  output logic       alu_src2_load_en,
  output logic       sel_field_load_en,
  output logic       rf_write_read,
  output logic [7:0] retired_count,
  output logic       illegal_seen
);

  seq_state_t state_q, state_d;
  logic [7:0] retired_q, retired_d;
  logic       illegal_q, illegal_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    retired_d         = retired_q;
    illegal_d         = illegal_q;
    instr_ready       = 1'b0;
    ir_load_en        = 1'b0;
    pc_load_en        = 1'b0;
    alu_src1_load_en  = 1'b0;
    alu_src2_load_en  = 1'b0;
    sel_field_load_en = 1'b0;
    rf_write_read     = 1'b0;
    data_bus_sel      = NOP;
    unique case (state_q)
      S_FETCH: begin
        // Gated by reset so nothing is taken while reset is held.
        instr_ready = reset_n && !halt;
        ir_load_en  = instr_valid && instr_ready;
        if (ir_load_en) state_d = S_SEL_R1;
      end
      S_SEL_R1: begin
        if (!op_legal(opcode)) begin
          illegal_d = 1'b1;
          state_d   = S_PC_INC;
        end else begin
          data_bus_sel      = IR_R1;
          sel_field_load_en = 1'b1;
          state_d           = S_READ_R1;
        end
      end
      S_READ_R1: begin
        data_bus_sel     = RF;
        alu_src1_load_en = 1'b1;
        state_d = imm_instruction ? S_IMM_R2 : S_SEL_R2;
      end
      S_SEL_R2: begin
        data_bus_sel      = IR_R2;
        sel_field_load_en = 1'b1;
        state_d           = S_READ_R2;
      end
      S_READ_R2: begin
        data_bus_sel     = RF;
        alu_src2_load_en = 1'b1;
        state_d          = S_SEL_RD;
      end
      S_IMM_R2: begin
        data_bus_sel     = IR_R2;
        alu_src2_load_en = 1'b1;
        state_d          = S_SEL_RD;
      end
      S_SEL_RD: begin
        data_bus_sel      = IR_RD;
        sel_field_load_en = 1'b1;
        state_d           = S_WRITE_RD;
      end
      S_WRITE_RD: begin
        data_bus_sel  = ALU;
        rf_write_read = 1'b1;
        state_d       = S_PC_INC;
      end
      S_PC_INC: begin
        data_bus_sel = PC_PLUS_4;
        pc_load_en   = 1'b1;
        retired_d    = retired_q + 8'd1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_count = retired_q;
  assign illegal_seen  = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a small datapath model
// (IR, PC, operand regs, register file, ALU) driven by the DUT controls.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic       instr_ready;
  logic       halt;
  logic [3:0] opcode;
  logic       imm_instruction;
  data_bus_t  data_bus_sel;
  logic       pc_load_en, ir_load_en, alu_src1_load_en;
  logic       alu_src2_load_en, sel_field_load_en, rf_write_read;
  logic [7:0] retired_count;
  logic       illegal_seen;

  instr_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halt(halt), .opcode(opcode), .imm_instruction(imm_instruction),
    .data_bus_sel(data_bus_sel), .pc_load_en(pc_load_en),
    .ir_load_en(ir_load_en), .alu_src1_load_en(alu_src1_load_en),
    .alu_src2_load_en(alu_src2_load_en),
    .sel_field_load_en(sel_field_load_en),
    .rf_write_read(rf_write_read), .retired_count(retired_count),
    .illegal_seen(illegal_seen)
  );

  always #5 clock = ~clock;

  // ---------------- datapath model ----------------
  // word: [3:0] op, [6:4] r1, [9:7] r2/imm, [12:10] rd
  logic [15:0] instr_word, ir_m;
  logic [7:0]  pc_m, src1_m, src2_m, bus_m;
  logic [2:0]  sel_m;
  logic [7:0]  rf_m [8];
  logic        pre_we;
  logic [2:0]  pre_addr;
  logic [7:0]  pre_data;

  function automatic logic [7:0] alu(input logic [3:0] op,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    case (op)
      OP_ADD, OP_ADDI: return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_SLL:  return a << b[2:0];
      OP_SRL:  return a >> b[2:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[2:0]);
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    bus_m = 8'h00;
    case (data_bus_sel)
      IR_R1:     bus_m = {5'd0, ir_m[6:4]};
      IR_R2:     bus_m = {5'd0, ir_m[9:7]};
      IR_RD:     bus_m = {5'd0, ir_m[12:10]};
      RF:        bus_m = rf_m[sel_m];
      ALU:       bus_m = alu(ir_m[3:0], src1_m, src2_m);
      PC_PLUS_4: bus_m = pc_m + 8'd4;
      default:   bus_m = 8'h00;
    endcase
  end

  assign opcode          = ir_m[3:0];
  assign imm_instruction = (ir_m[3:0] == OP_ADDI);

  initial begin
    ir_m = '0; pc_m = '0; src1_m = '0; src2_m = '0; sel_m = '0;
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
  end

  always @(posedge clock) begin
    if (ir_load_en)        ir_m   <= instr_word;
    if (pc_load_en)        pc_m   <= bus_m;
    if (alu_src1_load_en)  src1_m <= bus_m;
    if (alu_src2_load_en)  src2_m <= bus_m;
    if (sel_field_load_en) sel_m  <= bus_m[2:0];
    if (rf_write_read)     rf_m[sel_m] <= bus_m;
    if (pre_we)            rf_m[pre_addr] <= pre_data;
  end

  // ---------------- scoreboard ----------------
  // en bits: ir, pc, src1, src2, sel, rf_write
  typedef struct packed {
    data_bus_t  bus;
    logic [5:0] en;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_active = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [5:0] en_now();
    return {ir_load_en, pc_load_en, alu_src1_load_en,
            alu_src2_load_en, sel_field_load_en, rf_write_read};
  endfunction

  always @(negedge clock) begin
    obs_t o, e;
    if (reset_n) begin
      o.bus = data_bus_sel;
      o.en  = en_now();
      if (exp_q.size() > 0 && (mon_active || ir_load_en)) begin
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL seq: got bus=%0d en=%b expected bus=%0d en=%b",
                   o.bus, o.en, e.bus, e.en);
        end
        mon_active = (exp_q.size() > 0);
      end else if (o.bus != NOP || o.en != 6'b0) begin
        checks++;
        failures++;
        $display("FAIL unexpected: bus=%0d en=%b with nothing expected",
                 o.bus, o.en);
      end
      if (rf_write_read) begin
        checks++;
        if (data_bus_sel != ALU) begin
          failures++;
          $display("FAIL rf_write: asserted with bus=%0d expected ALU",
                   data_bus_sel);
        end
      end
    end
  end

  function automatic logic [15:0] mk(input logic [3:0] op,
                                     input logic [2:0] r1,
                                     input logic [2:0] r2,
                                     input logic [2:0] rd);
    return {3'b000, rd, r2, r1, op};
  endfunction

  task automatic push(input data_bus_t b, input logic [5:0] en);
    obs_t o;
    o.bus = b;
    o.en  = en;
    exp_q.push_back(o);
  endtask

  task automatic push_seq(input logic [15:0] w);
    push(NOP, 6'b100000);
    if (w[3:0] > OP_NOR) begin
      push(NOP, 6'b000000);
    end else begin
      push(IR_R1, 6'b000010);
      push(RF,    6'b001000);
      if (w[3:0] == OP_ADDI) begin
        push(IR_R2, 6'b000100);
      end else begin
        push(IR_R2, 6'b000010);
        push(RF,    6'b000100);
      end
      push(IR_RD, 6'b000010);
      push(ALU,   6'b000001);
    end
    push(PC_PLUS_4, 6'b010000);
  endtask

  task automatic issue(input logic [15:0] w, input bit hold);
    bit got = 1'b0;
    push_seq(w);
    instr_word  = w;
    instr_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clock);
      got = ir_load_en;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clock); #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(posedge clock); #1;
      done = (exp_q.size() == 0);
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_state(input data_bus_t b, input bit src2);
    bit hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(posedge clock); #1;
      hit = (data_bus_sel == b) && (alu_src2_load_en == src2);
    end
    if (!hit) chk("state_timeout", 0, 1);
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pc_save;
    reset_n = 1'b0; instr_valid = 1'b0; halt = 1'b0;
    instr_word = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clock); #1;
    chk("rst_bus", data_bus_sel, NOP);
    chk("rst_en", int'(en_now()), 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_illegal", illegal_seen, 0);
    reset_n = 1'b1;
    #1 chk("rst_ready", instr_ready, 1);

    preload(3'd1, 8'd5);
    preload(3'd2, 8'd7);
    preload(3'd4, 8'd10);
    preload(3'd6, 8'hAA);

    // ADD r3 = r1 + r2
    issue(mk(OP_ADD, 3'd1, 3'd2, 3'd3), 1'b0);
    wait_done();
    chk("add_rd", rf_m[3], 12);
    chk("add_pc", pc_m, 4);
    chk("add_retired", retired_count, 1);

    // ADDI r5 = r4 + 6
    issue(mk(OP_ADDI, 3'd4, 3'd6, 3'd5), 1'b0);
    wait_done();
    chk("addi_rd", rf_m[5], 16);
    chk("addi_pc", pc_m, 8);
    chk("addi_retired", retired_count, 2);

    // illegal opcode
    issue(mk(4'hF, 3'd0, 3'd0, 3'd6), 1'b0);
    wait_done();
    chk("ill_flag", illegal_seen, 1);
    chk("ill_no_write", rf_m[6], 8'hAA);
    chk("ill_pc", pc_m, 12);
    chk("ill_retired", retired_count, 3);

    // halt raised during WRITE_RD
    issue(mk(OP_SUB, 3'd2, 3'd1, 3'd7), 1'b0);
    wait_state(ALU, 1'b0);
    halt = 1'b1;
    instr_word = mk(OP_XOR, 3'd1, 3'd2, 3'd0);
    instr_valid = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("halt_ready", instr_ready, 0);
      chk("halt_irload", ir_load_en, 0);
    end
    chk("halt_retired", retired_count, 4);
    push_seq(instr_word);
    halt = 1'b0;
    #1 chk("halt_release_load", ir_load_en, 1);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    wait_done();
    chk("sub_rd", rf_m[7], 2);
    chk("xor_rd", rf_m[0], 2);
    chk("halt_pc", pc_m, 20);
    chk("halt_retired2", retired_count, 5);
    chk("ill_sticky", illegal_seen, 1);

    // reset during READ_R2
    issue(mk(OP_ADD, 3'd1, 3'd2, 3'd3), 1'b0);
    wait_state(RF, 1'b1);
    pc_save = pc_m;
    exp_q.delete();
    mon_active = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bus", data_bus_sel, NOP);
    chk("mid_rst_en", int'(en_now()), 0);
    chk("mid_rst_retired", retired_count, 0);
    chk("mid_rst_illegal", illegal_seen, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1 chk("mid_rst_ready", instr_ready, 1);
    repeat (3) @(posedge clock);
    #1 chk("mid_rst_pc", pc_m, pc_save);

    // 256 back-to-back NOR
    for (int i = 0; i < 256; i++)
      issue(mk(OP_NOR, 3'd1, 3'd2, 3'd3), i < 255);
    wait_done();
    chk("wrap_retired", retired_count, 0);
    chk("wrap_rd", rf_m[3], 8'hF8);
    chk("wrap_pc", pc_m, pc_save);
    chk("wrap_illegal", illegal_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Microcode sequencer for the 8-bit common-bus CPU. It owns the shared data bus: each cycle it selects one bus driver and asserts the load/write enables for the PC, IR, ALU operand registers, register-select register and register file. It takes instructions from the external switch interface through a valid/ready handshake and walks each one through fetch, operand read, execute/writeback and PC increment. It sits beside the datapath top level, in place of the hard-wired microcode block.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset: asynchronous, active-low.
- `instr_valid`  in  1  external instruction word is stable and may be taken.
- `instr_ready`  out  1  sequencer can accept an instruction this cycle.
- `halt`  in  1  while high, no new instruction is accepted; the in-flight instruction still completes.
- `opcode`  in  4  IR[3:0], as registered in the datapath.
- `imm_instruction`  in  1  IR opcode is ADDI.
- `data_bus_sel`  out  `data_bus_t`  common-bus driver select.
- `pc_load_en`, `ir_load_en`, `alu_src1_load_en`, `alu_src2_load_en`, `sel_field_load_en`  out  1 each  register load enables.
- `rf_write_read`  out  1  1 = register file write from the bus, 0 = read.
- `retired_count`  out  8  count of instructions completed.
- `illegal_seen`  out  1  sticky flag: an illegal opcode was fetched.

## Operation
- Legal opcodes: ADD, ADDI, SUB, XOR, NAND, SLL, SRL, SRA, NOR. Every other opcode is illegal.
- Any enable not listed for a state is 0. `data_bus_sel` is NOP unless a state lists otherwise.

State behaviour:
- FETCH
  - `instr_ready` = !`halt`.
  - `ir_load_en` = `instr_valid` && `instr_ready` (this is the only Mealy output).
  - On accept, go to SEL_R1; otherwise stay in FETCH.
- SEL_R1
  - If the opcode is illegal: set `illegal_seen`, go to PC_INC, assert no other enables.
  - Otherwise: bus = IR_R1, `sel_field_load_en`=1, go to READ_R1.
- READ_R1
  - bus = RF, `alu_src1_load_en`=1.
  - Go to IMM_R2 if `imm_instruction`, else SEL_R2.
- SEL_R2: bus = IR_R2, `sel_field_load_en`=1, go to READ_R2.
- READ_R2: bus = RF, `alu_src2_load_en`=1, go to SEL_RD.
- IMM_R2: bus = IR_R2 (the 3-bit immediate, zero-extended), `alu_src2_load_en`=1, go to SEL_RD.
- SEL_RD: bus = IR_RD, `sel_field_load_en`=1, go to WRITE_RD.
- WRITE_RD: bus = ALU, `rf_write_read`=1, go to PC_INC.
- PC_INC
  - bus = PC_PLUS_4, `pc_load_en`=1.
  - `retired_count` += 1, wrapping 255 -> 0. Illegal instructions also retire.
  - Go to FETCH.

Boundary conditions:
- At most one bus driver is selected per cycle.
- `rf_write_read`=1 only in WRITE_RD.
- `halt` is ignored outside FETCH.
- `instr_valid` is ignored outside FETCH.
- `illegal_seen` is cleared only by reset.

## Timing
- Reset (asynchronous, immediate):
  - state = FETCH, `retired_count`=0, `illegal_seen`=0.
  - All enables 0, `data_bus_sel`=NOP.
  - `instr_ready` follows !`halt` as soon as reset deasserts.
- Reset mid-instruction abandons it: no further enables are asserted and the PC is not incremented.
- State outputs are registered-state decodes (Moore) and are valid for the whole cycle. Datapath registers capture at the end of that cycle.
- Cycles from the accept edge to the next FETCH:
  - register ops: 7 (SEL_R1, READ_R1, SEL_R2, READ_R2, SEL_RD, WRITE_RD, PC_INC).
  - ADDI: 6.
  - illegal: 2.
- `opcode` and `imm_instruction` are sampled no earlier than SEL_R1, one cycle after the IR load.
- Back-to-back: with `instr_valid` held high and `halt` low, the next accept occurs in the FETCH cycle right after PC_INC. Throughput is one register op per 8 cycles.

## Structure
- Add `seq_state_t` (enum of the 9 states) to the shared defines package alongside `data_bus_t` and the opcode constants.
- Opcode legality is a function in the same package.
- Single module. The retire counter and the sticky flag are inline; no sub-module is warranted.

## Test plan
- Reset: pulse `reset_n` low mid-READ_R2 -> outputs go to the reset values immediately; next cycle is FETCH with `instr_ready`=1.
- ADD: `instr_valid`=1 with opcode ADD, r1=1, r2=2, rd=3 (R1=5, R2=7) -> bus sequence IR_R1, RF, IR_R2, RF, IR_RD, ALU, PC_PLUS_4; R3=12; PC +4; `retired_count`=1; 8 cycles total.
- ADDI: opcode ADDI, imm field=6, R1=10 -> IMM_R2 path taken; R_rd=16; 7 cycles total.
- Illegal opcode 4'hF -> `illegal_seen`=1 stays set, no RF write, PC +4, `retired_count` increments.
- Halt: `halt`=1 raised during WRITE_RD -> PC_INC completes; `instr_ready`=0 and `ir_load_en`=0 in FETCH until `halt` drops; then accept in the same cycle.
- Wrap: 256 back-to-back NOR instructions -> `retired_count` returns to 0; no cycle ever has two bus selects or `rf_write_read`=1 outside WRITE_RD (assertion).
